decision_sequencer: RTL and testbench

Collects one cooperate/defect decision per player per round for the prisoner's-dilemma game and presents a stable, registered decision pair to the game controller's payoff path. It opens a decision window on each `round_start` pulse, locks each player's first submission, and closes the window when both players have submitted or a timeout expires. On timeout, an absent player's previous decision is substituted. It also keeps a short per-player decision history for LED/HEX display.

---
 rtl/decision_sequencer_if.sv | 33 +++
 rtl/decision_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_decision_sequencer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/decision_sequencer_if.sv
// Decision sequencer bus: game/round control, player buttons, resolved decisions and history.
// The master side (game controller/players) drives the inputs; the slave side is the sequencer.
interface decision_sequencer_if #(
    parameter int HIST_DEPTH = 8
);
    logic                  game_active;
    logic                  round_start;
    logic                  submit_a;
    logic                  submit_b;
    logic                  choice_a;
    logic                  choice_b;
    logic                  decision_a;
    logic                  decision_b;
    logic                  decisions_ready;
    logic                  locked_a;
    logic                  locked_b;
    logic                  timed_out_a;
    logic                  timed_out_b;
    logic [HIST_DEPTH-1:0] history_a;
    logic [HIST_DEPTH-1:0] history_b;

    modport master (
        output game_active, round_start, submit_a, submit_b, choice_a, choice_b,
        input  decision_a, decision_b, decisions_ready, locked_a, locked_b,
        input  timed_out_a, timed_out_b, history_a, history_b
    );

    modport slave (
        input  game_active, round_start, submit_a, submit_b, choice_a, choice_b,
        output decision_a, decision_b, decisions_ready, locked_a, locked_b,
        output timed_out_a, timed_out_b, history_a, history_b
    );
endinterface

// File: rtl/decision_sequencer.sv
// Prisoner's-dilemma decision sequencer: opens a window per round, locks first submissions,
// resolves on both-locked or timeout (substituting the previous decision) and keeps a history.
module decision_sequencer #(
    parameter int TIMEOUT_CYCLES = 250_000_000,
    parameter int HIST_DEPTH     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    decision_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    localparam logic [27:0] TERM_COUNT = 28'(TIMEOUT_CYCLES - 1);

    state_t                state_r;
    state_t                next_state_s;
    logic                  start_s;
    logic                  accept_s;
    logic                  resolve_s;
    logic                  fresh_r;
    logic                  has_prev_a_r;
    logic                  has_prev_b_r;
    logic [27:0]           count_r;
    logic                  locked_a_r;
    logic                  locked_b_r;
    logic                  choice_a_r;
    logic                  choice_b_r;
    logic                  decision_a_r;
    logic                  decision_b_r;
    logic                  ready_r;
    logic                  timed_out_a_r;
    logic                  timed_out_b_r;
    logic [HIST_DEPTH-1:0] history_a_r;
    logic [HIST_DEPTH-1:0] history_b_r;
    logic                  lock_a_next_s;
    logic                  lock_b_next_s;
    logic                  choice_a_next_s;
    logic                  choice_b_next_s;
    logic                  res_a_s;
    logic                  res_b_s;

    // Lock/choice values as they will stand after this edge; a locked choice is never overwritten.
    always_comb begin
        lock_a_next_s   = locked_a_r | bus.submit_a;
        lock_b_next_s   = locked_b_r | bus.submit_b;
        choice_a_next_s = locked_a_r ? choice_a_r : bus.choice_a;
        choice_b_next_s = locked_b_r ? choice_b_r : bus.choice_b;
        if (lock_a_next_s) begin
            res_a_s = choice_a_next_s;
        end else begin
            res_a_s = has_prev_a_r ? history_a_r[0] : 1'b0;
        end
        if (lock_b_next_s) begin
            res_b_s = choice_b_next_s;
        end else begin
            res_b_s = has_prev_b_r ? history_b_r[0] : 1'b0;
        end
    end

    // Next-state logic; round_start in COLLECT restarts the window and suppresses any resolve.
    always_comb begin
        next_state_s = state_r;
        start_s      = 1'b0;
        accept_s     = 1'b0;
        resolve_s    = 1'b0;
        if (!bus.game_active) begin
            next_state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.round_start) begin
                        start_s      = 1'b1;
                        next_state_s = ST_COLLECT;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end
                ST_COLLECT: begin
                    if (bus.round_start) begin
                        start_s      = 1'b1;
                        next_state_s = ST_COLLECT;
                    end else if ((lock_a_next_s && lock_b_next_s) || (count_r == TERM_COUNT)) begin
                        accept_s     = 1'b1;
                        resolve_s    = 1'b1;
                        next_state_s = ST_HOLD;
                    end else begin
                        accept_s     = 1'b1;
                        next_state_s = ST_COLLECT;
                    end
                end
                ST_HOLD: begin
                    if (bus.round_start) begin
                        start_s      = 1'b1;
                        next_state_s = ST_COLLECT;
                    end else begin
                        next_state_s = ST_HOLD;
                    end
                end
                default: begin
                    next_state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Window datapath: locks, counter, resolved decisions and histories.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fresh_r       <= 1'b1;
            has_prev_a_r  <= 1'b0;
            has_prev_b_r  <= 1'b0;
            count_r       <= 28'd0;
            locked_a_r    <= 1'b0;
            locked_b_r    <= 1'b0;
            choice_a_r    <= 1'b0;
            choice_b_r    <= 1'b0;
            decision_a_r  <= 1'b0;
            decision_b_r  <= 1'b0;
            ready_r       <= 1'b0;
            timed_out_a_r <= 1'b0;
            timed_out_b_r <= 1'b0;
            history_a_r   <= '0;
            history_b_r   <= '0;
        end else begin
            ready_r <= 1'b0;
            if (!bus.game_active) begin
                fresh_r <= 1'b1;
            end else if (start_s) begin
                locked_a_r    <= 1'b0;
                locked_b_r    <= 1'b0;
                timed_out_a_r <= 1'b0;
                timed_out_b_r <= 1'b0;
                count_r       <= 28'd0;
                fresh_r       <= 1'b0;
                if (fresh_r) begin
                    history_a_r  <= '0;
                    history_b_r  <= '0;
                    has_prev_a_r <= 1'b0;
                    has_prev_b_r <= 1'b0;
                end
            end else if (accept_s) begin
                locked_a_r <= lock_a_next_s;
                locked_b_r <= lock_b_next_s;
                choice_a_r <= choice_a_next_s;
                choice_b_r <= choice_b_next_s;
                if (resolve_s) begin
                    decision_a_r  <= res_a_s;
                    decision_b_r  <= res_b_s;
                    timed_out_a_r <= ~lock_a_next_s;
                    timed_out_b_r <= ~lock_b_next_s;
                    history_a_r   <= {history_a_r[HIST_DEPTH-2:0], res_a_s};
                    history_b_r   <= {history_b_r[HIST_DEPTH-2:0], res_b_s};
                    has_prev_a_r  <= 1'b1;
                    has_prev_b_r  <= 1'b1;
                    ready_r       <= 1'b1;
                end else begin
                    count_r <= count_r + 28'd1;
                end
            end
        end
    end

    assign bus.decision_a      = decision_a_r;
    assign bus.decision_b      = decision_b_r;
    assign bus.decisions_ready = ready_r;
    assign bus.locked_a        = locked_a_r;
    assign bus.locked_b        = locked_b_r;
    assign bus.timed_out_a     = timed_out_a_r;
    assign bus.timed_out_b     = timed_out_b_r;
    assign bus.history_a       = history_a_r;
    assign bus.history_b       = history_b_r;
endmodule

// File: tb/tb_decision_sequencer.sv
// Directed, table-driven bench for decision_sequencer with TIMEOUT_CYCLES=16.
module tb_decision_sequencer;
    localparam int TO = 16;

    // in  = {game_active, round_start, submit_a, choice_a, submit_b, choice_b}
    // fl  = {decisions_ready, decision_a, decision_b, locked_a, locked_b, timed_out_a, timed_out_b}
    typedef struct {
        string      name;
        logic [5:0] in;
        logic [6:0] fl;
        logic [7:0] ha;
        logic [7:0] hb;
    } vec_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    vec_t tbl [13];

    decision_sequencer_if #(.HIST_DEPTH(8)) bus ();

    decision_sequencer #(.TIMEOUT_CYCLES(TO), .HIST_DEPTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [22:0] observed();
        return {bus.decisions_ready, bus.decision_a, bus.decision_b, bus.locked_a, bus.locked_b,
                bus.timed_out_a, bus.timed_out_b, bus.history_a, bus.history_b};
    endfunction

    task automatic compare(input string name, input logic [22:0] exp);
        logic [22:0] act;
        act = observed();
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got fl=%b ha=%h hb=%h, expected fl=%b ha=%h hb=%h", name,
                     act[22:16], act[15:8], act[7:0], exp[22:16], exp[15:8], exp[7:0]);
        end
    endtask

    // Drive one cycle of inputs, clock once, check outputs 1 time unit after the edge.
    task automatic apply(input string name, input logic [5:0] in, input logic [6:0] fl,
                         input logic [7:0] ha, input logic [7:0] hb);
        {bus.game_active, bus.round_start, bus.submit_a, bus.choice_a, bus.submit_b, bus.choice_b} = in;
        @(posedge clk);
        #1;
        compare(name, {fl, ha, hb});
    endtask

    task automatic wait_window(input string name, input logic [6:0] fl,
                               input logic [7:0] ha, input logic [7:0] hb);
        for (int i = 0; i < TO - 2; i++) begin
            apply(name, 6'b100000, fl, ha, hb);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        {bus.game_active, bus.round_start, bus.submit_a, bus.choice_a, bus.submit_b, bus.choice_b} = 6'b000000;

        tbl[0]  = '{"start1",      6'b110000, 7'b0000000, 8'h00, 8'h00};
        tbl[1]  = '{"both_same",   6'b101110, 7'b1101100, 8'h01, 8'h00};
        tbl[2]  = '{"hold1",       6'b100000, 7'b0101100, 8'h01, 8'h00};
        tbl[3]  = '{"start2",      6'b110000, 7'b0100000, 8'h01, 8'h00};
        tbl[4]  = '{"sub_a0",      6'b101000, 7'b0101000, 8'h01, 8'h00};
        tbl[5]  = '{"resub_a1",    6'b101100, 7'b0101000, 8'h01, 8'h00};
        tbl[6]  = '{"sub_b1",      6'b100011, 7'b1011100, 8'h02, 8'h01};
        tbl[7]  = '{"hold2",       6'b100000, 7'b0011100, 8'h02, 8'h01};
        tbl[8]  = '{"ga_low",      6'b000000, 7'b0011100, 8'h02, 8'h01};
        tbl[9]  = '{"ga_high",     6'b100000, 7'b0011100, 8'h02, 8'h01};
        tbl[10] = '{"submit_idle", 6'b101111, 7'b0011100, 8'h02, 8'h01};
        tbl[11] = '{"fresh_start", 6'b110000, 7'b0010000, 8'h00, 8'h00};
        tbl[12] = '{"sub_b_only",  6'b100011, 7'b0010100, 8'h00, 8'h00};

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        compare("reset_state", 23'd0);
        apply("idle_after_reset", 6'b000000, 7'b0000000, 8'h00, 8'h00);

        for (int i = 0; i < 13; i++) begin
            apply(tbl[i].name, tbl[i].in, tbl[i].fl, tbl[i].ha, tbl[i].hb);
        end

        // First-round timeout: a absent, no previous decision -> cooperate, flagged.
        wait_window("wait_to1", 7'b0010100, 8'h00, 8'h00);
        apply("timeout1", 6'b100000, 7'b1010110, 8'h00, 8'h01);

        // Set up decision_a=1, then time out a again: default repeats 1.
        apply("start_setup", 6'b110000, 7'b0010000, 8'h00, 8'h01);
        apply("setup_both",  6'b101110, 7'b1101100, 8'h01, 8'h02);
        apply("start_to2",   6'b110000, 7'b0100000, 8'h01, 8'h02);
        apply("sub_b0",      6'b100010, 7'b0100100, 8'h01, 8'h02);
        wait_window("wait_to2", 7'b0100100, 8'h01, 8'h02);
        apply("timeout2",    6'b100000, 7'b1100110, 8'h03, 8'h04);

        // Submit from a on the terminal-count edge is accepted, no timeout flag.
        apply("start_race",  6'b110000, 7'b0100000, 8'h03, 8'h04);
        apply("race_sub_b1", 6'b100011, 7'b0100100, 8'h03, 8'h04);
        wait_window("wait_race", 7'b0100100, 8'h03, 8'h04);
        apply("race_term",   6'b101000, 7'b1011100, 8'h06, 8'h09);
        apply("ready_single", 6'b100000, 7'b0011100, 8'h06, 8'h09);

        // round_start mid-window aborts: locks clear, no ready pulse.
        apply("start_abort", 6'b110000, 7'b0010000, 8'h06, 8'h09);
        apply("abort_sub_a", 6'b101100, 7'b0011000, 8'h06, 8'h09);
        apply("restart",     6'b110000, 7'b0010000, 8'h06, 8'h09);
        apply("after_abort", 6'b101111, 7'b1111100, 8'h0d, 8'h13);

        // Asynchronous reset between edges while locked_a is set.
        apply("start_rst",   6'b110000, 7'b0110000, 8'h0d, 8'h13);
        apply("rst_sub_a",   6'b101000, 7'b0111000, 8'h0d, 8'h13);
        {bus.game_active, bus.round_start, bus.submit_a, bus.choice_a, bus.submit_b, bus.choice_b} = 6'b100000;
        #3;
        reset = 1'b1;
        #1;
        compare("async_reset", 23'd0);
        #2;
        reset = 1'b0;
        apply("idle_ignores_sub", 6'b101111, 7'b0000000, 8'h00, 8'h00);
        apply("start_post_rst",   6'b110000, 7'b0000000, 8'h00, 8'h00);
        apply("both_post_rst",    6'b101111, 7'b1111100, 8'h01, 8'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
